uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised, oversampled UART receiver. Successor to the fixed 8N1 receiver:
//  - configurable data width, parity mode and stop-bit count
//  - input synchroniser, start-glitch rejection and 3-sample majority vote
//  - parity, framing, break and overrun reporting
//  - held-data / acknowledge interface
//  Sits between the pad-side rx line and the RX FIFO or host logic. Shares the
//  baud-rate generator's s_tick (OS ticks per bit).
// PARAMETERS
//  DBIT        8   data bits per frame, 5..9, received LSB first
//  OS          16  s_tick pulses per bit period, even, >= 8
//  PARITY      0   0 = none, 1 = even, 2 = odd
//  SB          1   stop bits, 1 or 2
//  SYNC_STAGES 2   rx synchroniser flops, >= 2
// PORTS
//  clk          in   1     system clock; one clock, all logic on posedge
//  reset_n      in   1     reset is asynchronous and active-low
//  rx           in   1     serial input, asynchronous to clk, idle high
//  s_tick       in   1     oversample strobe, 1-clk pulse, OS per bit
//  rd_ack       in   1     consumer has taken dout; clears dout_valid
//  dout         out  DBIT  last accepted data word
//  dout_valid   out  1     dout holds unread data (sticky until rd_ack)
//  rx_done_tick out  1     1-clk pulse when any frame completes
//  parity_err   out  1     1-clk pulse with rx_done_tick: parity mismatch
//  frame_err    out  1     1-clk pulse with rx_done_tick: a stop bit sampled 0
//  break_det    out  1     1-clk pulse with rx_done_tick: data, parity and stop all 0
//  overrun_err  out  1     1-clk pulse: frame completed while dout_valid = 1
// BEHAVIOUR
//  Reset: state = IDLE, counters 0, sync chain all 1s.
//    dout = 0; dout_valid, rx_done_tick, all error pulses = 0.
//  rxs is the synchronised rx (SYNC_STAGES flops, reset to 1); all decisions use rxs.
//  s counts s_tick, log2(OS) bits; n counts bits; s_tick gates every counter advance.
//  FSM states:
//  - IDLE: rxs = 0 -> START, s = 0.
//  - START: on the tick where s = OS/2-1, re-test rxs.
//      1 -> IDLE (glitch, no flags).
//      0 -> DATA, s = 0, n = 0.
//  - DATA: samples taken on ticks s = OS-3, OS-2, OS-1; bit = majority of the 3.
//      At s = OS-1: shift bit in at MSB (LSB-first order), s = 0.
//      n = DBIT-1 -> PARITY if PARITY != 0, else STOP; otherwise n + 1.
//  - PARITY: same majority sampling; compare to XOR of data
//      (even: XOR ^ bit must be 0; odd: must be 1). -> STOP, s = 0, n = 0.
//  - STOP: majority sample each stop bit at s = OS-1.
//      Any 0 sample sets the frame_err flag.
//      After stop bit SB: -> IDLE (half a bit early, to allow resync).
//  Completion: rx_done_tick and flags are registered, asserted the clk after the
//    completing s_tick.
//    - dout_valid = 0: dout <= shift reg; dout_valid <= 1 (same cycle as rx_done_tick).
//    - dout_valid = 1 and rd_ack = 0 that cycle: dout unchanged, new word dropped,
//      overrun_err pulses.
//  Flags on errored frames:
//    - Data is still delivered on parity_err or frame_err.
//    - break_det implies frame_err; the word is not loaded into dout.
//  rd_ack clears dout_valid next clk; rd_ack with dout_valid = 0 is ignored.
//    rd_ack coincident with completion: the new word loads, dout_valid stays 1,
//    no overrun.
//  After break/frame_err, IDLE waits for rxs = 1 before arming a new start
//    (no retrigger on a held-low line).
//  reset_n low mid-frame: immediate return to reset values; partial frame discarded.
//  s_tick absent: FSM frozen in its current state.
// TESTING
//  1. 8N1, OS=16, send 0xA5 -> dout=0xA5, dout_valid=1, one rx_done_tick, no error flags.
//  2. PARITY=1, send 0x07 with parity 0 -> rx_done_tick + parity_err, dout=0x07.
//     Same frame with PARITY=2 -> no parity_err.
//  3. rx low pulse of 4 ticks -> stays IDLE; no rx_done_tick.
//     1-tick glitch inside a data bit -> majority vote restores the bit.
//  4. Two frames 0x11, 0x22 with no rd_ack -> dout=0x11, overrun_err on the second.
//     rd_ack between frames -> dout=0x22, no overrun.
//  5. Hold rx low > 12 bit times -> one break_det + frame_err.
//     No further frames until rx returns high; then 0x3C is received correctly.
//  6. DBIT=9, SB=2, send 0x1FF -> dout=0x1FF.
//     Second stop bit 0 -> frame_err.
//     Assert reset_n mid-data -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable width, parity and stop bits.
// Synchronised input, start-glitch rejection, 3-sample majority vote, held-data output.
module uart_rx_cfg #(
    parameter int DBIT        = 8,
    parameter int OS          = 16,
    parameter int PARITY      = 0,
    parameter int SB          = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd_ack,
    output logic [DBIT-1:0] dout,
    output logic            dout_valid,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun_err,
    output logic [2:0]      o_dbg_state
);

    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(DBIT + 1);
    localparam logic ODD_PAR = (PARITY == 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [SW-1:0]          r_s;
    logic [NW-1:0]          r_n;
    logic [DBIT-1:0]        r_shift;
    logic [1:0]             r_smp;
    logic                   r_par_bit;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_stop_one;
    logic                   r_need_high;
    logic [DBIT-1:0]        r_dout;
    logic                   r_valid;
    logic                   r_done;
    logic                   r_perr_q;
    logic                   r_ferr_q;
    logic                   r_brk_q;
    logic                   r_ovr_q;

    logic w_rxs;
    logic w_bit;
    logic w_last;
    logic w_complete;
    logic w_frame_err;
    logic w_break;

    assign w_rxs  = r_sync[SYNC_STAGES-1];
    // Third sample is the live synchronised value on the closing tick of the bit.
    assign w_bit  = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rxs) | (r_smp[0] & w_rxs);
    assign w_last = (r_s == SW'(OS - 1));
    assign w_complete  = s_tick && (r_state == ST_STOP) && w_last && (r_n == NW'(SB - 1));
    assign w_frame_err = r_ferr | ~w_bit;
    assign w_break     = ~r_stop_one & ~w_bit & ~r_par_bit & (r_shift == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '1;
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_smp       <= '0;
            r_par_bit   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop_one  <= 1'b0;
            r_need_high <= 1'b0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_perr_q    <= 1'b0;
            r_ferr_q    <= 1'b0;
            r_brk_q     <= 1'b0;
            r_ovr_q     <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rx};
            r_done   <= 1'b0;
            r_perr_q <= 1'b0;
            r_ferr_q <= 1'b0;
            r_brk_q  <= 1'b0;
            r_ovr_q  <= 1'b0;
            if (rd_ack) r_valid <= 1'b0;

            // A break frame is flagged but never replaces the held word.
            if (w_complete) begin
                r_done   <= 1'b1;
                r_perr_q <= r_perr;
                r_ferr_q <= w_frame_err;
                r_brk_q  <= w_break;
                if (!w_break) begin
                    if (!r_valid || rd_ack) begin
                        r_dout  <= r_shift;
                        r_valid <= 1'b1;
                    end else begin
                        r_ovr_q <= 1'b1;
                    end
                end
            end

            if (s_tick) begin
                if (r_s == SW'(OS - 3)) r_smp[0] <= w_rxs;
                if (r_s == SW'(OS - 2)) r_smp[1] <= w_rxs;
                case (r_state)
                    ST_IDLE: begin
                        if (r_need_high) begin
                            if (w_rxs) r_need_high <= 1'b0;
                        end else if (!w_rxs) begin
                            r_state <= ST_START;
                            r_s     <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_s == SW'(OS / 2 - 1)) begin
                            if (w_rxs) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state    <= ST_DATA;
                                r_s        <= '0;
                                r_n        <= '0;
                                r_par_bit  <= 1'b0;
                                r_perr     <= 1'b0;
                                r_ferr     <= 1'b0;
                                r_stop_one <= 1'b0;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (w_last) begin
                            r_shift <= {w_bit, r_shift[DBIT-1:1]};
                            r_s     <= '0;
                            if (r_n == NW'(DBIT - 1)) begin
                                r_n     <= '0;
                                r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (w_last) begin
                            r_par_bit <= w_bit;
                            r_perr    <= (^r_shift) ^ w_bit ^ ODD_PAR;
                            r_state   <= ST_STOP;
                            r_s       <= '0;
                            r_n       <= '0;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_last) begin
                            r_s <= '0;
                            if (!w_bit) r_ferr <= 1'b1;
                            else        r_stop_one <= 1'b1;
                            // Leave mid-stop-bit; a low line after an error must rise before re-arming.
                            if (r_n == NW'(SB - 1)) begin
                                r_state     <= ST_IDLE;
                                r_need_high <= w_frame_err;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_valid;
    assign rx_done_tick = r_done;
    assign parity_err   = r_perr_q;
    assign frame_err    = r_ferr_q;
    assign break_det    = r_brk_q;
    assign overrun_err  = r_ovr_q;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances (8N1, 8E1, 8O1, 9N2) on separate rx lines.
// Pulse outputs are counted on the falling edge; checks compare count deltas and held data.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic [1:0] div = 2'd0;
    logic       rx_v [4];
    logic [3:0] rd_ack_v;
    logic [7:0] dout_a, dout_e, dout_o;
    logic [8:0] dout_9;
    logic [3:0] valid_v, done_v, perr_v, ferr_v, brk_v, ovr_v;
    logic [2:0] st_v [4];

    int c_done[4], c_perr[4], c_ferr[4], c_brk[4], c_ovr[4];
    int b_done[4], b_perr[4], b_ferr[4], b_brk[4], b_ovr[4];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div    <= div + 2'd1;
        s_tick <= (div == 2'd3);
    end

    uart_rx_cfg #(.DBIT(8), .OS(16), .PARITY(0), .SB(1)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .rx(rx_v[0]), .s_tick(s_tick), .rd_ack(rd_ack_v[0]),
        .dout(dout_a), .dout_valid(valid_v[0]), .rx_done_tick(done_v[0]), .parity_err(perr_v[0]),
        .frame_err(ferr_v[0]), .break_det(brk_v[0]), .overrun_err(ovr_v[0]), .o_dbg_state(st_v[0]));

    uart_rx_cfg #(.DBIT(8), .OS(16), .PARITY(1), .SB(1)) u_8e1 (
        .clk(clk), .reset_n(reset_n), .rx(rx_v[1]), .s_tick(s_tick), .rd_ack(rd_ack_v[1]),
        .dout(dout_e), .dout_valid(valid_v[1]), .rx_done_tick(done_v[1]), .parity_err(perr_v[1]),
        .frame_err(ferr_v[1]), .break_det(brk_v[1]), .overrun_err(ovr_v[1]), .o_dbg_state(st_v[1]));

    uart_rx_cfg #(.DBIT(8), .OS(16), .PARITY(2), .SB(1)) u_8o1 (
        .clk(clk), .reset_n(reset_n), .rx(rx_v[2]), .s_tick(s_tick), .rd_ack(rd_ack_v[2]),
        .dout(dout_o), .dout_valid(valid_v[2]), .rx_done_tick(done_v[2]), .parity_err(perr_v[2]),
        .frame_err(ferr_v[2]), .break_det(brk_v[2]), .overrun_err(ovr_v[2]), .o_dbg_state(st_v[2]));

    uart_rx_cfg #(.DBIT(9), .OS(16), .PARITY(0), .SB(2)) u_9n2 (
        .clk(clk), .reset_n(reset_n), .rx(rx_v[3]), .s_tick(s_tick), .rd_ack(rd_ack_v[3]),
        .dout(dout_9), .dout_valid(valid_v[3]), .rx_done_tick(done_v[3]), .parity_err(perr_v[3]),
        .frame_err(ferr_v[3]), .break_det(brk_v[3]), .overrun_err(ovr_v[3]), .o_dbg_state(st_v[3]));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i]) c_done[i] <= c_done[i] + 1;
            if (perr_v[i]) c_perr[i] <= c_perr[i] + 1;
            if (ferr_v[i]) c_ferr[i] <= c_ferr[i] + 1;
            if (brk_v[i])  c_brk[i]  <= c_brk[i] + 1;
            if (ovr_v[i])  c_ovr[i]  <= c_ovr[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
            #1;
        end
    endtask

    // bits[] is the whole frame LSB first (start bit at index 0); gbit inverts tick 7 of that bit.
    task automatic send_frame(input int idx, input logic [15:0] bits, input int nb, input int gbit);
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 16; t++) begin
                rx_v[idx] = (b == gbit && t == 7) ? ~bits[b] : bits[b];
                tick_wait(1);
            end
        end
        rx_v[idx] = 1'b1;
    endtask

    task automatic ack(input int idx);
        rd_ack_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        rd_ack_v[idx] = 1'b0;
    endtask

    task automatic snap();
        b_done = c_done;
        b_perr = c_perr;
        b_ferr = c_ferr;
        b_brk  = c_brk;
        b_ovr  = c_ovr;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx_v[i] = 1'b1;
            c_done[i] = 0; c_perr[i] = 0; c_ferr[i] = 0; c_brk[i] = 0; c_ovr[i] = 0;
        end
        rd_ack_v = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset dout_a", dout_a, 8'h00);
        check_eq("reset dout_9", dout_9, 9'h000);
        check_eq("reset valid", valid_v, 4'b0000);
        check_eq("reset pulses", {done_v, perr_v, ferr_v, brk_v, ovr_v}, 20'h0);
        check_eq("reset state", st_v[0], 3'd0);
        reset_n = 1'b1;
        tick_wait(8);

        // 8N1 0xA5
        snap();
        send_frame(0, {1'b1, 8'hA5, 1'b0}, 10, -1);
        tick_wait(4);
        check_eq("a5 dout", dout_a, 8'hA5);
        check_eq("a5 valid", valid_v[0], 1'b1);
        check_eq("a5 done", c_done[0] - b_done[0], 1);
        check_eq("a5 errs", (c_perr[0]-b_perr[0]) + (c_ferr[0]-b_ferr[0]) + (c_brk[0]-b_brk[0]) + (c_ovr[0]-b_ovr[0]), 0);
        ack(0);
        check_eq("a5 ack clears", valid_v[0], 1'b0);

        // 0x07 with parity bit 0: wrong for even, right for odd
        snap();
        send_frame(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
        send_frame(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
        tick_wait(4);
        check_eq("even done", c_done[1] - b_done[1], 1);
        check_eq("even perr", c_perr[1] - b_perr[1], 1);
        check_eq("even dout", dout_e, 8'h07);
        check_eq("odd done", c_done[2] - b_done[2], 1);
        check_eq("odd perr", c_perr[2] - b_perr[2], 0);
        check_eq("odd dout", dout_o, 8'h07);
        ack(1);
        ack(2);

        // 4-tick start glitch, then a 1-tick glitch inside data bit 3
        snap();
        rx_v[0] = 1'b0;
        tick_wait(4);
        rx_v[0] = 1'b1;
        tick_wait(32);
        check_eq("glitch no done", c_done[0] - b_done[0], 0);
        check_eq("glitch idle", st_v[0], 3'd0);
        send_frame(0, {1'b1, 8'h5A, 1'b0}, 10, 4);
        tick_wait(4);
        check_eq("vote dout", dout_a, 8'h5A);
        check_eq("vote done", c_done[0] - b_done[0], 1);
        ack(0);

        // Overrun: two frames without ack, then with ack between
        snap();
        send_frame(0, {1'b1, 8'h11, 1'b0}, 10, -1);
        send_frame(0, {1'b1, 8'h22, 1'b0}, 10, -1);
        tick_wait(4);
        check_eq("ovr dout", dout_a, 8'h11);
        check_eq("ovr count", c_ovr[0] - b_ovr[0], 1);
        check_eq("ovr done", c_done[0] - b_done[0], 2);
        ack(0);
        snap();
        send_frame(0, {1'b1, 8'h11, 1'b0}, 10, -1);
        ack(0);
        send_frame(0, {1'b1, 8'h22, 1'b0}, 10, -1);
        tick_wait(4);
        check_eq("noovr dout", dout_a, 8'h22);
        check_eq("noovr count", c_ovr[0] - b_ovr[0], 0);
        ack(0);

        // Break: line low for 13 bit times, then recovery
        snap();
        rx_v[0] = 1'b0;
        tick_wait(208);
        check_eq("brk count", c_brk[0] - b_brk[0], 1);
        check_eq("brk ferr", c_ferr[0] - b_ferr[0], 1);
        check_eq("brk done once", c_done[0] - b_done[0], 1);
        check_eq("brk not loaded", {valid_v[0], dout_a}, {1'b0, 8'h22});
        rx_v[0] = 1'b1;
        tick_wait(32);
        send_frame(0, {1'b1, 8'h3C, 1'b0}, 10, -1);
        tick_wait(4);
        check_eq("post brk dout", dout_a, 8'h3C);
        check_eq("post brk done", c_done[0] - b_done[0], 2);
        ack(0);

        // 9 data bits, 2 stop bits
        snap();
        send_frame(3, {2'b11, 9'h1FF, 1'b0}, 12, -1);
        tick_wait(4);
        check_eq("9b dout", dout_9, 9'h1FF);
        check_eq("9b ferr", c_ferr[3] - b_ferr[3], 0);
        ack(3);
        snap();
        send_frame(3, {2'b01, 9'h0AB, 1'b0}, 12, -1);
        tick_wait(4);
        check_eq("sb2 ferr", c_ferr[3] - b_ferr[3], 1);
        check_eq("sb2 brk", c_brk[3] - b_brk[3], 0);
        check_eq("sb2 dout", dout_9, 9'h0AB);
        check_eq("sb2 valid", valid_v[3], 1'b1);

        // Reset in the middle of a data field
        send_frame(3, {3'b101, 1'b0}, 4, -1);
        check_eq("mid state data", st_v[3], 3'd2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid rst dout", dout_9, 9'h000);
        check_eq("mid rst valid", valid_v[3], 1'b0);
        check_eq("mid rst state", st_v[3], 3'd0);
        reset_n = 1'b1;
        tick_wait(32);
        snap();
        send_frame(3, {2'b11, 9'h155, 1'b0}, 12, -1);
        tick_wait(4);
        check_eq("after rst dout", dout_9, 9'h155);
        check_eq("after rst done", c_done[3] - b_done[3], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
